// File: rtl/change_dispenser.sv
// change_dispenser
// Sequential change-return engine. Latches a change amount on start and pays
// it out as a series of handshaked coin requests, greedy over two
// denominations, falling back to the low coin when the high hopper is empty.
// A remainder that cannot be paid raises a one-cycle fault pulse.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start, amount         dispense request and value (accepted only in IDLE)
//   en                    dispense enable; low pauses before the next coin
//   hi_empty, lo_empty    hopper empty flags
//   coin_ack              hopper accepted the pending coin request
//   coin_valid, coin_sel  coin request and denomination (1 = high)
//   busy, done, fault     status; done/fault are one-cycle pulses
//   remaining, coin_count value still owed, coins issued (saturating)
module change_dispenser #(
  parameter int AMT_W    = 8,
  parameter int DENOM_HI = 5,
  parameter int DENOM_LO = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             en,
  input  logic             hi_empty,
  input  logic             lo_empty,
  input  logic             coin_ack,
  output logic             coin_valid,
  output logic             coin_sel,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [AMT_W-1:0] remaining,
  output logic [AMT_W-1:0] coin_count
);

  localparam logic [AMT_W-1:0] HI_V = AMT_W'(DENOM_HI);
  localparam logic [AMT_W-1:0] LO_V = AMT_W'(DENOM_LO);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_ISSUE, S_DONE, S_FAULT
  } state_t;

  state_t           r_state, w_next;
  logic [AMT_W-1:0] r_remaining, r_coin_count;
  logic             r_coin_sel;
  logic             w_can_hi, w_can_lo;

  // Greedy choice: high coin first, low coin as fallback.
  assign w_can_hi = (r_remaining >= HI_V) && !hi_empty;
  assign w_can_lo = (r_remaining >= LO_V) && !lo_empty;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = (amount != '0) ? S_SELECT : S_DONE;
      S_SELECT: begin
        if (r_remaining == '0)          w_next = S_DONE;
        else if (en) begin
          if (w_can_hi || w_can_lo)     w_next = S_ISSUE;
          else                          w_next = S_FAULT;
        end
      end
      S_ISSUE:  if (coin_ack) w_next = S_SELECT;
      S_DONE:   w_next = S_IDLE;
      S_FAULT:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Datapath: amount tracking, coin count and latched denomination.
  // coin_sel is captured in SELECT so it stays stable through ISSUE even if
  // hopper flags change while the request is outstanding.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_remaining  <= '0;
      r_coin_count <= '0;
      r_coin_sel   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start && amount != '0) begin
          r_remaining  <= amount;
          r_coin_count <= '0;
        end
        S_SELECT: if (r_remaining != '0 && en) begin
          if (w_can_hi)      r_coin_sel <= 1'b1;
          else if (w_can_lo) r_coin_sel <= 1'b0;
        end
        S_ISSUE: if (coin_ack) begin
          // SELECT guaranteed remaining >= chosen denomination
          r_remaining  <= r_remaining - (r_coin_sel ? HI_V : LO_V);
          if (r_coin_count != '1) r_coin_count <= r_coin_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output decode (from registered state only)
  always_comb begin
    coin_valid = (r_state == S_ISSUE);
    coin_sel   = r_coin_sel;
    busy       = (r_state != S_IDLE);
    done       = (r_state == S_DONE);
    fault      = (r_state == S_FAULT);
    remaining  = r_remaining;
    coin_count = r_coin_count;
  end

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;
  logic       clk = 1'b0;
  logic       rst_n, start, en, hi_empty, lo_empty, coin_ack;
  logic [7:0] amount;
  logic       coin_valid, coin_sel, busy, done, fault;
  logic [7:0] remaining, coin_count;
  int         n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  change_dispenser dut (
    .clk(clk), .rst_n(rst_n), .start(start), .amount(amount), .en(en),
    .hi_empty(hi_empty), .lo_empty(lo_empty), .coin_ack(coin_ack),
    .coin_valid(coin_valid), .coin_sel(coin_sel), .busy(busy), .done(done),
    .fault(fault), .remaining(remaining), .coin_count(coin_count)
  );

  // advance one rising edge, then settle before sampling/driving
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; amount = 0; en = 1; hi_empty = 0; lo_empty = 0; coin_ack = 0;
    tick(); tick();
    n_total++;
    if ({coin_valid, coin_sel, busy, done, fault, remaining, coin_count} !== 21'd0)
      $display("FAIL reset_outputs got v%b s%b b%b d%b f%b r%0d c%0d want all 0",
               coin_valid, coin_sel, busy, done, fault, remaining, coin_count);
    else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_nominal();
    int ev[8] = '{1, 0, 1, 0, 1, 0, 0, 0};
    int es[8] = '{1, 0, 0, 0, 0, 0, 0, 0};
    int er[8] = '{7, 2, 2, 1, 1, 0, 0, 0};
    int ed[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    int eb[8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    int sel_i = 0;
    int sels[3] = '{1, 0, 0};
    coin_ack = 1; amount = 8'd7; start = 1;
    tick();                       // edge 0
    start = 0;
    n_total++;
    if (busy !== 1'b1 || coin_valid !== 1'b0)
      $display("FAIL nom_edge0 got busy=%b valid=%b want 1/0", busy, coin_valid);
    else n_pass++;
    for (int k = 0; k < 8; k++) begin
      tick();                     // edge k+1
      n_total++;
      if (coin_valid !== ev[k][0] || remaining !== 8'(er[k]) || done !== ed[k][0] || busy !== eb[k][0])
        $display("FAIL nom_edge%0d got v%b r%0d d%b b%b want v%0d r%0d d%0d b%0d",
                 k + 1, coin_valid, remaining, done, busy, ev[k], er[k], ed[k], eb[k]);
      else n_pass++;
      if (ev[k] == 1) begin
        n_total++;
        if (coin_sel !== sels[sel_i][0])
          $display("FAIL nom_sel%0d got %b want %0d", sel_i, coin_sel, sels[sel_i]);
        else n_pass++;
        sel_i++;
      end
      if (k == 6) begin
        n_total++;
        if (coin_count !== 8'd3) $display("FAIL nom_count got %0d want 3", coin_count);
        else n_pass++;
      end
    end
    if (es[0] != 1) $display("FAIL nom_table");
  endtask

  task automatic test_delayed();
    coin_ack = 0; amount = 8'd5; start = 1;
    tick();                       // edge 0
    start = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_total++;
      if (coin_valid !== 1'b1 || coin_sel !== 1'b1)
        $display("FAIL dly_hold_edge%0d got v%b s%b want 1/1", k, coin_valid, coin_sel);
      else n_pass++;
    end
    coin_ack = 1;
    tick();                       // edge 5: ack taken
    coin_ack = 0;
    n_total++;
    if (coin_valid !== 1'b0 || remaining !== 8'd0 || done !== 1'b0)
      $display("FAIL dly_ack got v%b r%0d d%b want 0/0/0", coin_valid, remaining, done);
    else n_pass++;
    tick();                       // edge 6: done (immediate ack gives edge 3)
    n_total++;
    if (done !== 1'b1 || coin_count !== 8'd1)
      $display("FAIL dly_done got d%b c%0d want 1/1", done, coin_count);
    else n_pass++;
    tick();
  endtask

  task automatic test_hi_empty();
    int lo_coins = 0, hi_coins = 0, done_at = -1, faults = 0;
    hi_empty = 1; coin_ack = 1; amount = 8'd6; start = 1;
    tick();
    start = 0;
    for (int k = 1; k <= 20 && done_at < 0; k++) begin
      tick();
      if (coin_valid) begin
        if (coin_sel) hi_coins++; else lo_coins++;
      end
      if (fault) faults++;
      if (done) done_at = k;
    end
    n_total++;
    if (done_at !== 13) $display("FAIL hie_done_edge got %0d want 13", done_at);
    else n_pass++;
    n_total++;
    if (lo_coins !== 6 || hi_coins !== 0 || faults !== 0)
      $display("FAIL hie_coins got lo%0d hi%0d f%0d want 6/0/0", lo_coins, hi_coins, faults);
    else n_pass++;
    n_total++;
    if (coin_count !== 8'd6) $display("FAIL hie_count got %0d want 6", coin_count);
    else n_pass++;
    hi_empty = 0; coin_ack = 0;
    tick();
  endtask

  task automatic test_fault();
    lo_empty = 1; amount = 8'd3; start = 1;
    tick();                       // edge 0: SELECT
    start = 0;
    n_total++;
    if (fault !== 1'b0 || busy !== 1'b1) $display("FAIL flt_edge0 got f%b b%b want 0/1", fault, busy);
    else n_pass++;
    tick();                       // edge 1: FAULT
    n_total++;
    if (fault !== 1'b1 || remaining !== 8'd3 || coin_valid !== 1'b0 || done !== 1'b0)
      $display("FAIL flt_pulse got f%b r%0d v%b d%b want 1/3/0/0", fault, remaining, coin_valid, done);
    else n_pass++;
    tick();                       // edge 2: IDLE
    n_total++;
    if (fault !== 1'b0 || busy !== 1'b0 || remaining !== 8'd3 || done !== 1'b0 || coin_valid !== 1'b0)
      $display("FAIL flt_after got f%b b%b r%0d d%b v%b want 0/0/3/0/0", fault, busy, remaining, done, coin_valid);
    else n_pass++;
    lo_empty = 0;
  endtask

  task automatic test_pause();
    en = 1; coin_ack = 0; amount = 8'd10; start = 1;
    tick();                       // edge 0
    start = 0;
    tick();                       // edge 1: ISSUE high coin
    en = 0; start = 1; amount = 8'd3;   // pause plus stray start
    tick();                       // edge 2: request still held
    n_total++;
    if (coin_valid !== 1'b1 || coin_sel !== 1'b1 || remaining !== 8'd10)
      $display("FAIL pau_hold got v%b s%b r%0d want 1/1/10", coin_valid, coin_sel, remaining);
    else n_pass++;
    coin_ack = 1;
    tick();                       // edge 3: outstanding coin completes
    start = 0;
    n_total++;
    if (coin_valid !== 1'b0 || remaining !== 8'd5 || coin_count !== 8'd1)
      $display("FAIL pau_ack got v%b r%0d c%0d want 0/5/1", coin_valid, remaining, coin_count);
    else n_pass++;
    for (int k = 4; k <= 6; k++) begin
      tick();
      n_total++;
      if (coin_valid !== 1'b0 || busy !== 1'b1)
        $display("FAIL pau_idle_edge%0d got v%b b%b want 0/1", k, coin_valid, busy);
      else n_pass++;
    end
    en = 1;
    tick();                       // edge 7: resumes
    n_total++;
    if (coin_valid !== 1'b1 || coin_sel !== 1'b1)
      $display("FAIL pau_resume got v%b s%b want 1/1", coin_valid, coin_sel);
    else n_pass++;
    tick();                       // edge 8
    tick();                       // edge 9
    n_total++;
    if (done !== 1'b1 || remaining !== 8'd0 || coin_count !== 8'd2)
      $display("FAIL pau_done got d%b r%0d c%0d want 1/0/2", done, remaining, coin_count);
    else n_pass++;
    coin_ack = 0;
    tick();
  endtask

  task automatic test_reset_zero();
    amount = 8'd10; start = 1;
    tick();
    start = 0;
    tick();                       // ISSUE, ack held low
    n_total++;
    if (coin_valid !== 1'b1) $display("FAIL rz_issue got v%b want 1", coin_valid);
    else n_pass++;
    rst_n = 0;
    tick();
    rst_n = 1;
    n_total++;
    if ({coin_valid, coin_sel, busy, done, fault, remaining, coin_count} !== 21'd0)
      $display("FAIL rz_midreset got v%b s%b b%b d%b f%b r%0d c%0d want all 0",
               coin_valid, coin_sel, busy, done, fault, remaining, coin_count);
    else n_pass++;
    amount = 8'd0; start = 1;
    tick();
    start = 0;
    n_total++;
    if (done !== 1'b1 || coin_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL rz_zero_done got d%b v%b b%b want 1/0/1", done, coin_valid, busy);
    else n_pass++;
    tick();
    n_total++;
    if (done !== 1'b0 || busy !== 1'b0 || coin_valid !== 1'b0)
      $display("FAIL rz_zero_after got d%b b%b v%b want 0/0/0", done, busy, coin_valid);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_delayed();
    test_hi_empty();
    test_fault();
    test_pause();
    test_reset_zero();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
